// File: rtl/lpc_bus_monitor.sv
// Passive LPC bus monitor: decodes I/O and memory read/write cycles from LFRAME#/LAD
// and presents each completed cycle as one record behind a valid/ready handshake.
module lpc_bus_monitor #(
    parameter int MAX_WAIT = 64,
    parameter int WAIT_W   = 7
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lframe_i,
    input  logic [3:0]  lad_i,
    output logic        rec_valid_o,
    input  logic        rec_ready_i,
    output logic        rec_mem_o,
    output logic        rec_wr_o,
    output logic [31:0] rec_addr_o,
    output logic [7:0]  rec_data_o,
    output logic [3:0]  rec_sync_o,
    output logic        rec_err_o,
    output logic        overflow_o,
    output logic        abort_o,
    output logic [4:0]  state_o
);

    typedef enum logic [4:0] {
        IDLE  = 5'd0,
        START = 5'd1,
        CYCT  = 5'd2,
        ADDR  = 5'd3,
        WDATA = 5'd4,
        TAR   = 5'd5,
        SYNC  = 5'd6,
        RDATA = 5'd7,
        SKIP  = 5'd8
    } state_t;

    localparam logic [3:0] SYNC_READY = 4'b0000;
    localparam logic [3:0] SYNC_SHORT = 4'b0101;
    localparam logic [3:0] SYNC_LONG  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR = 4'b1010;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

    state_t            state, state_next;
    logic [3:0]        start_nib;
    logic              is_mem, is_wr;
    logic [31:0]       addr_q;
    logic [7:0]        data_q;
    logic [3:0]        sync_q;
    logic [2:0]        nib_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic       sync_ok, sync_wait, addr_last, abort_hit;
    logic       done;
    logic [3:0] done_sync;
    logic [7:0] done_data;

    assign sync_ok   = (lad_i == SYNC_READY) || (lad_i == SYNC_ERROR);
    assign sync_wait = (lad_i == SYNC_SHORT) || (lad_i == SYNC_LONG);
    assign addr_last = (nib_cnt == (is_mem ? 3'd7 : 3'd3));
    assign abort_hit = !lframe_i && (state != IDLE) && (state != START) && (state != SKIP);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        if (!lframe_i) begin
            state_next = START;
        end else begin
            unique case (state)
                IDLE:  state_next = IDLE;
                // The cycle-type nibble arrives on the first sample with LFRAME# high.
                START: begin
                    if (start_nib == 4'b0000 && !lad_i[3]) state_next = ADDR;
                    else                                   state_next = SKIP;
                end
                CYCT:  state_next = IDLE;
                ADDR:  if (addr_last) state_next = is_wr ? WDATA : TAR;
                WDATA: if (nib_cnt[0]) state_next = TAR;
                TAR:   if (nib_cnt[0]) state_next = SYNC;
                SYNC: begin
                    if (sync_ok)        state_next = is_wr ? IDLE : RDATA;
                    else if (sync_wait) state_next = (wait_cnt == WAIT_LAST) ? IDLE : SYNC;
                    else                state_next = IDLE;
                end
                RDATA: if (nib_cnt[0]) state_next = IDLE;
                SKIP:  state_next = SKIP;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        state_o = state;
    end

    // Record completion is decided on the edge that samples the cycle's final nibble.
    always_comb begin
        done      = 1'b0;
        done_sync = lad_i;
        done_data = 8'h00;
        if (lframe_i) begin
            if (state == SYNC) begin
                if (sync_ok && is_wr) begin
                    done      = 1'b1;
                    done_data = data_q;
                end else if (sync_wait && wait_cnt == WAIT_LAST) begin
                    done      = 1'b1;
                    done_sync = 4'hF;
                end else if (!sync_ok && !sync_wait) begin
                    done      = 1'b1;
                end
            end else if (state == RDATA && nib_cnt[0]) begin
                done      = 1'b1;
                done_sync = sync_q;
                done_data = {lad_i, data_q[3:0]};
            end
        end
    end

    // NOTE: the record register is a handful of flops, so it is reset along with the control state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            start_nib   <= 4'h0;
            is_mem      <= 1'b0;
            is_wr       <= 1'b0;
            addr_q      <= 32'h0;
            data_q      <= 8'h00;
            sync_q      <= 4'h0;
            nib_cnt     <= 3'd0;
            wait_cnt    <= '0;
            abort_o     <= 1'b0;
            overflow_o  <= 1'b0;
            rec_valid_o <= 1'b0;
            rec_mem_o   <= 1'b0;
            rec_wr_o    <= 1'b0;
            rec_addr_o  <= 32'h0;
            rec_data_o  <= 8'h00;
            rec_sync_o  <= 4'h0;
            rec_err_o   <= 1'b0;
        end else begin
            abort_o <= abort_hit;
            if (!lframe_i) start_nib <= lad_i;
            nib_cnt <= (state_next != state) ? 3'd0 : nib_cnt + 3'd1;

            case (state)
                START: begin
                    if (lframe_i) begin
                        is_mem <= lad_i[2];
                        is_wr  <= lad_i[1];
                        addr_q <= 32'h0;
                    end
                end
                ADDR:         addr_q <= {addr_q[27:0], lad_i};
                WDATA, RDATA: begin
                    if (!nib_cnt[0]) data_q[3:0] <= lad_i;
                    else             data_q[7:4] <= lad_i;
                end
                SYNC:         if (sync_ok) sync_q <= lad_i;
                default: ;
            endcase

            if (state != SYNC)                            wait_cnt <= '0;
            else if (sync_wait && wait_cnt != WAIT_MAX)   wait_cnt <= wait_cnt + 1'b1;

            if (done) begin
                if (!rec_valid_o || rec_ready_i) begin
                    rec_valid_o <= 1'b1;
                    rec_mem_o   <= is_mem;
                    rec_wr_o    <= is_wr;
                    rec_addr_o  <= is_mem ? addr_q : {16'h0, addr_q[15:0]};
                    rec_data_o  <= done_data;
                    rec_sync_o  <= done_sync;
                    rec_err_o   <= (done_sync != SYNC_READY);
                end else begin
                    overflow_o <= 1'b1;
                end
            end else if (rec_ready_i) begin
                rec_valid_o <= 1'b0;
            end
        end
    end

endmodule
